// File: rtl/bcd_digit_source.sv
// Multi-digit BCD up/down counter with a snapshot-and-scan digit stream port.
// Scan latency 1 cycle from scan_start to first digit; each digit held until digit_ready.
module bcd_digit_source #(
    parameter int DIGITS = 2,
    parameter int SELW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic [3:0]            digit_out,
    output logic [SELW-1:0]       digit_sel,
    output logic                  digit_valid,
    input  logic                  digit_ready,
    output logic                  scan_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } scan_state_t;

    localparam logic [SELW-1:0] SEL_ONE  = SELW'(1);
    localparam logic [SELW-1:0] LAST_SEL = SELW'(DIGITS - 1);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                load_err_q, load_bad;
    logic                all9, all0;

    scan_state_t         state_q;
    logic [4*DIGITS-1:0] shadow_q;
    logic [SELW-1:0]     sel_q, sel_nxt;
    logic [3:0]          nib_nxt;
    logic [3:0]          digit_out_q;
    logic [SELW-1:0]     digit_sel_q;
    logic                digit_valid_q;
    logic                scan_done_q;

    // Next counter value: ripple carry/borrow across digits within one cycle.
    always_comb begin
        logic       c;
        logic [3:0] nib;
        count_d  = count_q;
        load_bad = 1'b0;
        all9     = 1'b1;
        all0     = 1'b1;
        c        = 1'b1;
        nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            all9 = all9 & (count_q[4*i +: 4] == 4'd9);
            all0 = all0 & (count_q[4*i +: 4] == 4'd0);
        end
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = load_val[4*i +: 4];
                if (nib > 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                    load_bad          = 1'b1;
                end else begin
                    count_d[4*i +: 4] = nib;
                end
            end
        end else if (en) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = count_q[4*i +: 4];
                if (c) begin
                    if (up_dn) begin
                        if (nib == 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = nib + 4'd1;
                            c                 = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = nib - 4'd1;
                            c                 = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load & load_bad;
        end
    end

    assign tc = en & ~load & ~rst & (up_dn ? all9 : all0);

    // Digit following the current one, taken from the frozen snapshot.
    always_comb begin
        sel_nxt = sel_q + SEL_ONE;
        nib_nxt = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_nxt == SELW'(i)) begin
                nib_nxt = shadow_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            sel_q         <= '0;
            digit_out_q   <= 4'd0;
            digit_sel_q   <= '0;
            digit_valid_q <= 1'b0;
            scan_done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    scan_done_q <= 1'b0;
                    if (scan_start) begin
                        shadow_q      <= count_q;
                        sel_q         <= '0;
                        digit_out_q   <= count_q[3:0];
                        digit_sel_q   <= '0;
                        digit_valid_q <= 1'b1;
                        state_q       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (digit_ready) begin
                        if (sel_q == LAST_SEL) begin
                            digit_valid_q <= 1'b0;
                            scan_done_q   <= 1'b1;
                            state_q       <= S_DONE;
                        end else begin
                            sel_q       <= sel_nxt;
                            digit_sel_q <= sel_nxt;
                            digit_out_q <= nib_nxt;
                        end
                    end
                end
                S_DONE: begin
                    scan_done_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    digit_valid_q <= 1'b0;
                    scan_done_q   <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign count       = count_q;
    assign load_err    = load_err_q;
    assign scan_busy   = (state_q != S_IDLE);
    assign digit_out   = digit_out_q;
    assign digit_sel   = digit_sel_q;
    assign digit_valid = digit_valid_q;
    assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_bcd_digit_source.sv
// Bench for bcd_digit_source: integer reference model of the counter and snapshot scan.
module tb_bcd_digit_source;

    localparam int DIGITS = 2;
    localparam int SELW   = 3;
    localparam int MOD    = 100;

    logic                clk = 1'b0;
    logic                rst, en, up_dn, load, scan_start, digit_ready;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] count;
    logic                tc, load_err, scan_busy, digit_valid, scan_done;
    logic [3:0]          digit_out;
    logic [SELW-1:0]     digit_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int mcount  = 0;
    logic mlerr = 1'b0;

    bcd_digit_source #(.DIGITS(DIGITS), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .load_err(load_err),
        .scan_start(scan_start), .scan_busy(scan_busy), .digit_out(digit_out),
        .digit_sel(digit_sel), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int decode_load(input logic [4*DIGITS-1:0] x);
        int v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] <= 4'd9) v = v + int'(x[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic has_bad(input logic [4*DIGITS-1:0] x);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [3:0] digit_of(input int v, input int idx);
        int t;
        t = v;
        for (int i = 0; i < idx; i++) t = t / 10;
        return 4'(t % 10);
    endfunction

    function automatic logic exp_tc();
        if (rst || load || !en) return 1'b0;
        return up_dn ? (mcount == MOD - 1) : (mcount == 0);
    endfunction

    // One clock: update the model with the inputs seen at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mcount = 0;
            mlerr  = 1'b0;
        end else if (load) begin
            mcount = decode_load(load_val);
            mlerr  = has_bad(load_val);
        end else begin
            mlerr = 1'b0;
            if (en) mcount = up_dn ? (mcount + 1) % MOD : (mcount + MOD - 1) % MOD;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = '0; scan_start = 1'b0; digit_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; en = 1'b1;
        tick();
        tick();
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %h want 00", count); end
        n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b want 0", tc); end
        n_tests++; if ({load_err, scan_busy, digit_valid, scan_done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {load_err, scan_busy, digit_valid, scan_done}); end
        n_tests++; if ({digit_out, digit_sel} !== '0) begin
            n_fail++; $display("FAIL reset_digit got out=%h sel=%0d want 0/0", digit_out, digit_sel); end
        idle_inputs();
    endtask

    task automatic test_count_up();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            n_tests++; if (tc !== exp_tc()) begin n_fail++; $display("FAIL up_tc at %0d got %b want %b", mcount, tc, exp_tc()); end
            tick();
            n_tests++; if (count !== to_bcd(mcount)) begin n_fail++; $display("FAIL up_count got %h want %h", count, to_bcd(mcount)); end
        end
        n_tests++; if (count !== 8'h00) begin n_fail++; $display("FAIL up_wrap got %h want 00", count); end
        idle_inputs();
    endtask

    task automatic test_count_down();
        logic [7:0] seq [7];
        seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
        load = 1'b1; load_val = 8'h05;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_tests++; if (tc !== (count == 8'h00)) begin n_fail++; $display("FAIL down_tc at %h got %b", count, tc); end
            tick();
            n_tests++; if (count !== seq[i]) begin n_fail++; $display("FAIL down_count got %h want %h", count, seq[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_load_err();
        load = 1'b1; load_val = 8'h99;
        tick();
        n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL load_ok_err got %b want 0", load_err); end
        load_val = 8'h3C; en = 1'b1; up_dn = 1'b1;
        #1;
        n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL load_tc_forced got %b want 0", tc); end
        tick();
        n_tests++; if (count !== 8'h30) begin n_fail++; $display("FAIL load_bad_count got %h want 30", count); end
        n_tests++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL load_err_pulse got %b want 1", load_err); end
        load = 1'b0; en = 1'b0;
        tick();
        n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL load_err_clear got %b want 0", load_err); end
        n_tests++; if (count !== 8'h30) begin n_fail++; $display("FAIL load_hold got %h want 30", count); end
        rst = 1'b1; en = 1'b1; up_dn = 1'b0;
        #1;
        n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL rst_tc_forced got %b want 0", tc); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random_count();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = 1'($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            load_val = 8'($urandom);
            if (i < 60) begin load = 1'b1; load_val = (i % 2 == 0) ? 8'h99 : 8'h00; end
            #1;
            n_tests++; if (tc !== exp_tc()) begin n_fail++; $display("FAIL rnd_tc got %b want %b", tc, exp_tc()); end
            tick();
            n_tests++; if (count !== to_bcd(mcount)) begin n_fail++; $display("FAIL rnd_count got %h want %h", count, to_bcd(mcount)); end
            n_tests++; if (load_err !== mlerr) begin n_fail++; $display("FAIL rnd_load_err got %b want %b", load_err, mlerr); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scan_basic();
        load = 1'b1; load_val = 8'h47;
        tick();
        load = 1'b0; scan_start = 1'b1; digit_ready = 1'b1;
        tick();
        scan_start = 1'b0;
        n_tests++; if ({digit_valid, digit_out, digit_sel} !== {1'b1, 4'd7, 3'd0}) begin
            n_fail++; $display("FAIL scan_d0 got v=%b out=%h sel=%0d want 1/7/0", digit_valid, digit_out, digit_sel); end
        n_tests++; if (scan_busy !== 1'b1) begin n_fail++; $display("FAIL scan_busy got %b want 1", scan_busy); end
        tick();
        n_tests++; if ({digit_valid, digit_out, digit_sel} !== {1'b1, 4'd4, 3'd1}) begin
            n_fail++; $display("FAIL scan_d1 got v=%b out=%h sel=%0d want 1/4/1", digit_valid, digit_out, digit_sel); end
        tick();
        n_tests++; if ({digit_valid, scan_done, scan_busy} !== 3'b011) begin
            n_fail++; $display("FAIL scan_done got v/done/busy=%b want 011", {digit_valid, scan_done, scan_busy}); end
        tick();
        n_tests++; if ({scan_done, scan_busy} !== 2'b00) begin
            n_fail++; $display("FAIL scan_end got done/busy=%b want 00", {scan_done, scan_busy}); end
        idle_inputs();
    endtask

    task automatic test_scan_stall();
        load = 1'b1; load_val = 8'h47;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1; scan_start = 1'b1; digit_ready = 1'b0;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({digit_valid, digit_out, digit_sel} !== {1'b1, 4'd7, 3'd0}) begin
                n_fail++; $display("FAIL stall_hold got v=%b out=%h sel=%0d want 1/7/0", digit_valid, digit_out, digit_sel); end
            scan_start = (i == 2);
            tick();
        end
        scan_start = 1'b0;
        n_tests++; if (count !== to_bcd(mcount)) begin n_fail++; $display("FAIL stall_count got %h want %h", count, to_bcd(mcount)); end
        digit_ready = 1'b1;
        tick();
        n_tests++; if ({digit_out, digit_sel} !== {4'd4, 3'd1}) begin
            n_fail++; $display("FAIL stall_d1 got out=%h sel=%0d want 4/1", digit_out, digit_sel); end
        tick();
        n_tests++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b want 1", scan_done); end
        tick();
        tick();
        n_tests++; if ({digit_valid, scan_busy} !== 2'b00) begin
            n_fail++; $display("FAIL stall_no_requeue got v/busy=%b want 00", {digit_valid, scan_busy}); end
        idle_inputs();
    endtask

    task automatic test_random_scan();
        int snap, idx, cyc;
        logic rdy;
        for (int s = 0; s < 10; s++) begin
            en = 1'b1; up_dn = 1'($urandom);
            repeat ($urandom_range(0, 20)) tick();
            snap = mcount;
            scan_start = 1'b1;
            tick();
            scan_start = 1'b0;
            idx = 0;
            cyc = 0;
            while (idx < DIGITS && cyc < 200) begin
                n_tests++; if ({digit_valid, digit_out, digit_sel} !== {1'b1, digit_of(snap, idx), SELW'(idx)}) begin
                    n_fail++; $display("FAIL rscan_digit got v=%b out=%h sel=%0d want 1/%h/%0d",
                                       digit_valid, digit_out, digit_sel, digit_of(snap, idx), idx); end
                rdy = 1'($urandom);
                digit_ready = rdy;
                en = 1'($urandom);
                load = ($urandom_range(0, 9) == 0);
                load_val = 8'($urandom);
                scan_start = 1'($urandom);
                tick();
                if (rdy) idx++;
                cyc++;
            end
            n_tests++; if (idx != DIGITS) begin n_fail++; $display("FAIL rscan_timeout got %0d digits want %0d", idx, DIGITS); end
            scan_start = 1'b0; load = 1'b0; digit_ready = 1'b0;
            n_tests++; if ({digit_valid, scan_done, scan_busy} !== 3'b011) begin
                n_fail++; $display("FAIL rscan_done got v/done/busy=%b want 011", {digit_valid, scan_done, scan_busy}); end
            tick();
            n_tests++; if ({scan_done, scan_busy} !== 2'b00) begin
                n_fail++; $display("FAIL rscan_idle got done/busy=%b want 00", {scan_done, scan_busy}); end
            n_tests++; if (count !== to_bcd(mcount)) begin n_fail++; $display("FAIL rscan_count got %h want %h", count, to_bcd(mcount)); end
        end
        idle_inputs();
    endtask

    task automatic test_scan_reset();
        load = 1'b1; load_val = 8'h47;
        tick();
        load = 1'b0; scan_start = 1'b1; digit_ready = 1'b0;
        tick();
        scan_start = 1'b0;
        n_tests++; if (digit_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", digit_valid); end
        rst = 1'b1; digit_ready = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if ({digit_valid, scan_busy, scan_done} !== 3'b000) begin
            n_fail++; $display("FAIL rst_scan got v/busy/done=%b want 000", {digit_valid, scan_busy, scan_done}); end
        n_tests++; if (count !== 8'h00) begin n_fail++; $display("FAIL rst_scan_count got %h want 00", count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if ({scan_done, digit_valid} !== 2'b00) begin
                n_fail++; $display("FAIL rst_no_done got done/v=%b want 00", {scan_done, digit_valid}); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_count_up();
        test_count_down();
        test_load_err();
        test_random_count();
        test_scan_basic();
        test_scan_stall();
        test_random_scan();
        test_scan_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired, simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
